sl3p_rx_link_mon: RTL and testbench

Consumes the ECC-corrected 66-bit RX lane stream and its lock and ECC status flags from the armored 2-lane SerDes receive path.
Qualifies the link with a DOWN/TRAIN/UP state machine and gates data delivery to the core so only words received while UP pass through.
Keeps per-lane corrected and uncorrected error counters and a link-drop counter for management readout.
Runs entirely in the RX recovered-clock domain (rx_clk_out).

---
 rtl/sl3p_pkg.sv | 16 +
 rtl/sl3p_rx_link_mon_if.sv | 26 ++
 rtl/sl3p_sat_cntr.sv | 21 ++
 rtl/sl3p_rx_link_mon.sv | 139 +++++++++++++
 tb/tb_sl3p_rx_link_mon.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sl3p_pkg.sv
// Shared constants for the sl3p receive link: lane word width and link-state encoding.
package sl3p_pkg;

   localparam int WORD_W = 66;

   localparam logic [1:0] LS_DOWN  = 2'd0;
   localparam logic [1:0] LS_TRAIN = 2'd1;
   localparam logic [1:0] LS_UP    = 2'd2;

   typedef enum logic [1:0] {
      ST_DOWN  = LS_DOWN,
      ST_TRAIN = LS_TRAIN,
      ST_UP    = LS_UP
   } link_state_t;

endpackage

// File: rtl/sl3p_rx_link_mon_if.sv
// RX lane stream from the SerDes receive path and the qualified stream toward the core.
// Handshake: din_valid qualifies din, din_fix and din_fail in the same cycle; there is no
// ready, the producer never stalls. dout_valid likewise qualifies dout with no backpressure.
// word_lock and deskew_locked are levels, sampled every cycle.
interface sl3p_rx_link_mon_if #(
   parameter int LANES = 2
);
   logic [LANES*sl3p_pkg::WORD_W-1:0] din;
   logic                              din_valid;
   logic [LANES-1:0]                  din_fix;
   logic [LANES-1:0]                  din_fail;
   logic [LANES-1:0]                  word_lock;
   logic                              deskew_locked;
   logic [LANES*sl3p_pkg::WORD_W-1:0] dout;
   logic                              dout_valid;

   modport slave (
      input  din, din_valid, din_fix, din_fail, word_lock, deskew_locked,
      output dout, dout_valid
   );

   modport master (
      output din, din_valid, din_fix, din_fail, word_lock, deskew_locked,
      input  dout, dout_valid
   );
endinterface

// File: rtl/sl3p_sat_cntr.sv
// Saturating up-counter with synchronous clear that wins over an increment.
module sl3p_sat_cntr #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);
   logic [WIDTH-1:0] r_count;

   // Count events, stick at all-ones, clear takes priority.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)                    r_count <= '0;
      else if (clr)                   r_count <= '0;
      else if (inc && (r_count != '1)) r_count <= r_count + WIDTH'(1);
   end

   assign count = r_count;
endmodule

// File: rtl/sl3p_rx_link_mon.sv
// RX link qualification: DOWN/TRAIN/UP state machine, gated one-cycle datapath,
// per-lane ECC statistics and link-drop counter.
module sl3p_rx_link_mon
   import sl3p_pkg::*;
#(
   parameter int LANES       = 2,
   parameter int UP_WORDS    = 1024,
   parameter int WIN_BITS    = 16,
   parameter int FAIL_THRESH = 4,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                       clk,
   input  logic                       arst_n,
   sl3p_rx_link_mon_if.slave          rx,
   input  logic                       clr_counters,
   output logic                       link_up,
   output logic [1:0]                 link_state,
   output logic [LANES*CNT_WIDTH-1:0] fix_cnt,
   output logic [LANES*CNT_WIDTH-1:0] fail_cnt,
   output logic [15:0]                drop_cnt
);
   localparam int TRAIN_W = $clog2(UP_WORDS + 1);
   localparam int FW      = WIN_BITS + 1;
   localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(UP_WORDS - 1);
   localparam logic [FW-1:0]      THRESH     = FW'(FAIL_THRESH);

   link_state_t                 r_state;
   logic                        r_link_up;
   logic [TRAIN_W-1:0]          r_train_cnt;
   logic [WIN_BITS-1:0]         r_win_cnt;
   logic [FW-1:0]               r_win_fail;
   logic [LANES*WORD_W-1:0]     r_dout;
   logic                        r_dout_valid;

   logic                        w_locked;
   logic                        w_any_fail;
   logic                        w_wrap;
   logic [FW-1:0]               w_fail_next;
   logic                        w_drop;

   assign w_locked    = (&rx.word_lock) & rx.deskew_locked;
   assign w_any_fail  = rx.din_valid & (|rx.din_fail);
   // The word that rolls the window counter over opens the next window.
   assign w_wrap      = rx.din_valid & (&r_win_cnt);
   assign w_fail_next = w_wrap ? {{(FW-1){1'b0}}, w_any_fail}
                               : r_win_fail + FW'(w_any_fail);
   // Lock loss and threshold in the same cycle are one drop.
   assign w_drop      = (r_state == ST_UP) & (~w_locked | (w_fail_next >= THRESH));

   // Link state machine with training and window error tracking.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_state     <= ST_DOWN;
         r_link_up   <= 1'b0;
         r_train_cnt <= '0;
         r_win_cnt   <= '0;
         r_win_fail  <= '0;
      end else begin
         case (r_state)
            ST_DOWN: begin
               r_train_cnt <= '0;
               if (w_locked) r_state <= ST_TRAIN;
            end
            ST_TRAIN: begin
               if (!w_locked) begin
                  r_state     <= ST_DOWN;
                  r_train_cnt <= '0;
               end else if (w_any_fail) begin
                  r_train_cnt <= '0;
               end else if (rx.din_valid) begin
                  if (r_train_cnt == TRAIN_LAST) begin
                     r_state     <= ST_UP;
                     r_link_up   <= 1'b1;
                     r_train_cnt <= '0;
                     r_win_cnt   <= '0;
                     r_win_fail  <= '0;
                  end else begin
                     r_train_cnt <= r_train_cnt + TRAIN_W'(1);
                  end
               end
            end
            ST_UP: begin
               if (w_drop) begin
                  r_state   <= ST_DOWN;
                  r_link_up <= 1'b0;
               end else if (rx.din_valid) begin
                  r_win_cnt  <= r_win_cnt + WIN_BITS'(1);
                  r_win_fail <= w_fail_next;
               end
            end
            default: begin
               r_state   <= ST_DOWN;
               r_link_up <= 1'b0;
            end
         endcase
      end
   end

   // One-cycle datapath; delivery is qualified by the state before this cycle's update.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         r_dout       <= '0;
         r_dout_valid <= 1'b0;
      end else begin
         r_dout       <= rx.din;
         r_dout_valid <= rx.din_valid & (r_state == ST_UP);
      end
   end

   assign rx.dout       = r_dout;
   assign rx.dout_valid = r_dout_valid;
   assign link_up       = r_link_up;
   assign link_state    = r_state;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      sl3p_sat_cntr #(.WIDTH(CNT_WIDTH)) u_fix (
         .clk    (clk),
         .arst_n (arst_n),
         .clr    (clr_counters),
         .inc    (rx.din_valid & rx.din_fix[i]),
         .count  (fix_cnt[i*CNT_WIDTH +: CNT_WIDTH])
      );
      sl3p_sat_cntr #(.WIDTH(CNT_WIDTH)) u_fail (
         .clk    (clk),
         .arst_n (arst_n),
         .clr    (clr_counters),
         .inc    (rx.din_valid & rx.din_fail[i]),
         .count  (fail_cnt[i*CNT_WIDTH +: CNT_WIDTH])
      );
   end

   sl3p_sat_cntr #(.WIDTH(16)) u_drop (
      .clk    (clk),
      .arst_n (arst_n),
      .clr    (clr_counters),
      .inc    (w_drop),
      .count  (drop_cnt)
   );
endmodule

// File: tb/tb_sl3p_rx_link_mon.sv
// Directed bench for sl3p_rx_link_mon with a reference model and delivered-word scoreboard.
module tb_sl3p_rx_link_mon;
   import sl3p_pkg::*;

   localparam int LANES       = 2;
   localparam int UP_WORDS    = 8;
   localparam int WIN_BITS    = 4;
   localparam int FAIL_THRESH = 3;
   localparam int CNT_WIDTH   = 4;
   localparam int DW          = LANES * WORD_W;
   localparam int WIN_SIZE    = 1 << WIN_BITS;

   logic                       clk = 1'b0;
   logic                       arst_n = 1'b0;
   logic                       clr_counters = 1'b0;
   logic                       link_up;
   logic [1:0]                 link_state;
   logic [LANES*CNT_WIDTH-1:0] fix_cnt;
   logic [LANES*CNT_WIDTH-1:0] fail_cnt;
   logic [15:0]                drop_cnt;

   sl3p_rx_link_mon_if #(.LANES(LANES)) rx_if ();

   sl3p_rx_link_mon #(
      .LANES       (LANES),
      .UP_WORDS    (UP_WORDS),
      .WIN_BITS    (WIN_BITS),
      .FAIL_THRESH (FAIL_THRESH),
      .CNT_WIDTH   (CNT_WIDTH)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .rx           (rx_if),
      .clr_counters (clr_counters),
      .link_up      (link_up),
      .link_state   (link_state),
      .fix_cnt      (fix_cnt),
      .fail_cnt     (fail_cnt),
      .drop_cnt     (drop_cnt)
   );

   // Clock
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] exp_q[$];

   // Reference model state
   logic [1:0]           m_state;
   int                   m_train, m_win, m_wfail;
   logic [CNT_WIDTH-1:0] m_fix[LANES];
   logic [CNT_WIDTH-1:0] m_fail[LANES];
   logic [15:0]          m_drop;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = LS_DOWN; m_train = 0; m_win = 0; m_wfail = 0; m_drop = '0;
      for (int i = 0; i < LANES; i++) begin m_fix[i] = '0; m_fail[i] = '0; end
      exp_q.delete();
   endtask

   task automatic chk_model();
      chk("link_state", DW'(link_state), DW'(m_state));
      chk("link_up", DW'(link_up), DW'(m_state == LS_UP));
      for (int i = 0; i < LANES; i++) begin
         chk($sformatf("fix_cnt%0d", i), DW'(fix_cnt[i*CNT_WIDTH +: CNT_WIDTH]), DW'(m_fix[i]));
         chk($sformatf("fail_cnt%0d", i), DW'(fail_cnt[i*CNT_WIDTH +: CNT_WIDTH]), DW'(m_fail[i]));
      end
      chk("drop_cnt", DW'(drop_cnt), DW'(m_drop));
   endtask

   // Drive one cycle, advance the model, then check outputs 1 time unit after the edge.
   task automatic cyc(input logic v, input logic [1:0] fx, input logic [1:0] fl,
                      input logic [1:0] wl, input logic dl, input logic clr);
      logic [DW-1:0] d;
      logic locked, af, exp_dv, drop_ev;
      int nf, nw;
      for (int k = 0; k < DW; k++) d[k] = 1'($urandom_range(1, 0));
      rx_if.din = d; rx_if.din_valid = v; rx_if.din_fix = fx; rx_if.din_fail = fl;
      rx_if.word_lock = wl; rx_if.deskew_locked = dl; clr_counters = clr;

      locked  = (&wl) & dl;
      af      = v & (|fl);
      exp_dv  = v && (m_state == LS_UP);
      drop_ev = 1'b0;
      if (exp_dv) exp_q.push_back(d);
      case (m_state)
         LS_DOWN: if (locked) m_state = LS_TRAIN;
         LS_TRAIN: begin
            if (!locked) begin m_state = LS_DOWN; m_train = 0; end
            else if (af) m_train = 0;
            else if (v) begin
               m_train++;
               if (m_train == UP_WORDS) begin
                  m_state = LS_UP; m_train = 0; m_win = 0; m_wfail = 0;
               end
            end
         end
         LS_UP: begin
            nf = m_wfail; nw = m_win;
            if (v) begin
               nw = (m_win + 1) % WIN_SIZE;
               nf = (m_win == WIN_SIZE - 1) ? int'(af) : m_wfail + int'(af);
            end
            if (!locked || nf >= FAIL_THRESH) begin m_state = LS_DOWN; drop_ev = 1'b1; end
            else begin m_win = nw; m_wfail = nf; end
         end
         default: m_state = LS_DOWN;
      endcase
      if (clr) begin
         for (int i = 0; i < LANES; i++) begin m_fix[i] = '0; m_fail[i] = '0; end
         m_drop = '0;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (v && fx[i] && m_fix[i] != '1) m_fix[i]++;
            if (v && fl[i] && m_fail[i] != '1) m_fail[i]++;
         end
         if (drop_ev && m_drop != '1) m_drop++;
      end

      @(posedge clk); #1;
      chk("dout", rx_if.dout, d);
      chk("dout_valid", DW'(rx_if.dout_valid), DW'(exp_dv));
      if (rx_if.dout_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $error("FAIL sb_word: observed unexpected word %0h expected none", rx_if.dout);
         end else begin
            chk("sb_word", rx_if.dout, exp_q.pop_front());
         end
      end
      chk_model();
      clr_counters = 1'b0;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
   endtask

   // Valid locked word with optional fail on the given lane (lane index 2 means no fail).
   task automatic word_f(input int fail_lane);
      logic [1:0] fl;
      fl = '0;
      if (fail_lane < LANES) fl[fail_lane] = 1'b1;
      cyc(1'b1, 2'b00, fl, 2'b11, 1'b1, 1'b0);
   endtask

   initial begin
      rx_if.din = '0; rx_if.din_valid = 1'b0; rx_if.din_fix = '0; rx_if.din_fail = '0;
      rx_if.word_lock = '0; rx_if.deskew_locked = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", rx_if.dout, '0);
      chk("rst_dout_valid", DW'(rx_if.dout_valid), '0);
      chk_model();
      arst_n = 1'b1;

      // 1: lock, train on 8 clean words, deliver from the next word
      cyc(1'b1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      chk("t1_train", DW'(link_state), DW'(LS_TRAIN));
      clean(4);
      cyc(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      clean(3);
      chk("t1_still_train", DW'(link_state), DW'(LS_TRAIN));
      clean(1);
      chk("t1_up", DW'(link_state), DW'(LS_UP));
      chk("t1_first_undelivered", DW'(rx_if.dout_valid), '0);
      clean(1);
      chk("t1_first_delivered", DW'(rx_if.dout_valid), DW'(1));
      clean(2);
      cyc(1'b1, 2'b00, 2'b00, 2'b10, 1'b1, 1'b0);
      chk("t1_drop", DW'(drop_cnt), DW'(1));
      cyc(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
      chk("t1_clr_drop", DW'(drop_cnt), '0);

      // 2: fail on lane 1 at word 5 restarts training
      cyc(1'b1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      clean(4);
      word_f(1);
      clean(7);
      chk("t2_train", DW'(link_state), DW'(LS_TRAIN));
      clean(1);
      chk("t2_up", DW'(link_state), DW'(LS_UP));
      chk("t2_fail1", DW'(fail_cnt[CNT_WIDTH +: CNT_WIDTH]), DW'(1));
      chk("t2_fix0", DW'(fix_cnt[0 +: CNT_WIDTH]), '0);

      // 3: three fails in one window force DOWN; dropping word still delivered
      word_f(2); word_f(0); word_f(2); word_f(2); word_f(1); word_f(2);
      word_f(0);
      chk("t3_down", DW'(link_state), DW'(LS_DOWN));
      chk("t3_last_delivered", DW'(rx_if.dout_valid), DW'(1));
      chk("t3_drop", DW'(drop_cnt), DW'(1));

      // 4: window wrap reloads the fail count with the wrap word's fail
      cyc(1'b1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      clean(8);
      for (int w = 1; w <= 25; w++) begin
         if (w == 3 || w == 16 || w == 25) word_f(0);
         else if (w == 10 || w == 20) word_f(1);
         else if (w == 7) cyc(1'b1, 2'b10, 2'b00, 2'b11, 1'b1, 1'b0);
         else word_f(2);
         if (w == 24) chk("t4_still_up", DW'(link_state), DW'(LS_UP));
      end
      chk("t4_down", DW'(link_state), DW'(LS_DOWN));
      chk("t4_drop", DW'(drop_cnt), DW'(2));

      // 5: lock loss coincident with threshold fail counts once
      cyc(1'b1, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
      clean(8);
      word_f(0); word_f(1);
      cyc(1'b1, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0);
      chk("t5_down", DW'(link_state), DW'(LS_DOWN));
      chk("t5_drop", DW'(drop_cnt), DW'(3));

      // 6: saturation, clear beats event, async reset mid-UP
      for (int i = 0; i < 20; i++) cyc(1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0);
      chk("t6_sat", DW'(fix_cnt[0 +: CNT_WIDTH]), DW'(15));
      cyc(1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 1'b1);
      chk("t6_clr", DW'(fix_cnt[0 +: CNT_WIDTH]), '0);
      cyc(1'b1, 2'b01, 2'b00, 2'b11, 1'b1, 1'b0);
      cyc(1'b1, 2'b11, 2'b00, 2'b11, 1'b1, 1'b0);
      chk("t6_pre_rst_up", DW'(link_up), DW'(1));
      #2 arst_n = 1'b0;
      #1;
      chk("t6_rst_state", DW'(link_state), DW'(LS_DOWN));
      chk("t6_rst_up", DW'(link_up), '0);
      chk("t6_rst_dout", rx_if.dout, '0);
      chk("t6_rst_dv", DW'(rx_if.dout_valid), '0);
      chk("t6_rst_fix", DW'(fix_cnt), '0);
      chk("t6_rst_fail", DW'(fail_cnt), '0);
      chk("t6_rst_drop", DW'(drop_cnt), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
